// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder memory-side slave.
package mem_responder_pkg;

    localparam int          DEFAULT_DATA_WIDTH = 16;
    localparam int          DEFAULT_ADDR_WIDTH = 16;
    localparam int          MAX_READ_LATENCY   = 4;
    localparam logic [15:0] LFSR_SEED          = 16'hACE1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    // Fibonacci LFSR step, taps 16,14,13,11 (bits 15,13,12,10).
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/mem_resp_delay_line.sv
// Shift register carrying {valid, data} for DEPTH cycles; DEPTH=0 is a wire.
// Each stage's data only loads alongside a valid, so the output data holds between pulses.
module mem_resp_delay_line #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = clk ^ reset;
            assign valid_o     = valid_i;
            assign data_o      = data_i;
        end else begin : g_shift
            logic [DEPTH:0]        valid_q;
            logic [DATA_WIDTH-1:0] data_q [DEPTH+1];

            assign valid_q[0] = valid_i;
            assign data_q[0]  = data_i;

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        valid_q[gi+1] <= 1'b0;
                        data_q[gi+1]  <= '0;
                    end else begin
                        valid_q[gi+1] <= valid_q[gi];
                        if (valid_q[gi]) begin
                            data_q[gi+1] <= data_q[gi];
                        end
                    end
                end
            end

            assign valid_o = valid_q[DEPTH];
            assign data_o  = data_q[DEPTH];
        end
    endgenerate

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: word RAM cleared by a post-reset sweep, write-first reads
// returned after READ_LATENCY cycles. MEM_RESPONDER_STALL_EN adds LFSR-driven backpressure.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int MEM_DEPTH_LOG2 = 8,
    parameter int READ_LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    input  logic                  r_avalid,
    output logic                  r_aready,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_dvalid,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  w_valid,
    output logic                  w_ready
);

    localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int LAT       = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;

    typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;
    localparam idx_t INIT_LAST = '1;

    state_t                state_q;
    idx_t                  init_cnt_q;
    logic                  r_aready_q;
    logic                  w_ready_q;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

`ifdef MEM_RESPONDER_STALL_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    assign lfsr_d = lfsr_step(lfsr_q);
`endif

    idx_t r_idx;
    idx_t w_idx;
    logic rd_fire;
    logic wr_fire;

    assign r_idx   = r_addr[MEM_DEPTH_LOG2-1:0];
    assign w_idx   = w_addr[MEM_DEPTH_LOG2-1:0];
    assign rd_fire = r_avalid && r_aready_q;
    assign wr_fire = w_valid && w_ready_q;

    // Upper address bits alias onto the RAM and are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{r_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2], w_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            r_aready_q <= 1'b0;
            w_ready_q  <= 1'b0;
`ifdef MEM_RESPONDER_STALL_EN
            lfsr_q     <= LFSR_SEED;
`endif
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == INIT_LAST) begin
                        state_q <= ST_RUN;
`ifdef MEM_RESPONDER_STALL_EN
                        r_aready_q <= ~lfsr_q[0];
                        w_ready_q  <= ~lfsr_q[1];
`else
                        r_aready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
`endif
                    end
                end
                ST_RUN: begin
`ifdef MEM_RESPONDER_STALL_EN
                    lfsr_q     <= lfsr_d;
                    r_aready_q <= ~lfsr_d[0];
                    w_ready_q  <= ~lfsr_d[1];
`else
                    r_aready_q <= 1'b1;
                    w_ready_q  <= 1'b1;
`endif
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // Single RAM write port shared by the clearing sweep and requester writes.
    logic                  mem_we;
    idx_t                  mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = w_idx;
        mem_wdata = w_data;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt_q;
            mem_wdata = '0;
        end else if (wr_fire) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read; a same-edge write to the same word is forwarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= (wr_fire && (w_idx == r_idx)) ? w_data : mem[r_idx];
            end
        end
    end

    mem_resp_delay_line #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (LAT - 1)
    ) u_delay (
        .clk    (clk),
        .reset  (reset),
        .valid_i(rd_valid_q),
        .data_i (rd_data_q),
        .valid_o(r_dvalid),
        .data_o (r_data)
    );

    assign r_aready = r_aready_q;
    assign w_ready  = w_ready_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed plan steps plus randomized traffic
// against an array/queue reference model. Works with or without MEM_RESPONDER_STALL_EN.
module tb_mem_responder;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int MDL = 8;
    localparam int RL  = 2;
    localparam int NW  = 1 << MDL;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] r_addr = '0;
    logic          r_avalid = 1'b0;
    logic          r_aready;
    logic [DW-1:0] r_data;
    logic          r_dvalid;
    logic [AW-1:0] w_addr = '0;
    logic [DW-1:0] w_data = '0;
    logic          w_valid = 1'b0;
    logic          w_ready;

    mem_responder #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .MEM_DEPTH_LOG2(MDL),
        .READ_LATENCY  (RL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .r_addr  (r_addr),
        .r_avalid(r_avalid),
        .r_aready(r_aready),
        .r_data  (r_data),
        .r_dvalid(r_dvalid),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .w_valid (w_valid),
        .w_ready (w_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [DW-1:0] data;
        int            edge_n;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] model_mem [NW];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int idx_of(input logic [AW-1:0] a);
        return int'(a) % NW;
    endfunction

    // Every returned read must be the next expected one, on exactly the right edge.
    always @(negedge clk) begin
        if (!reset && r_dvalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_dvalid", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                $display("READ addr=0x%04h data=0x%04h expected=0x%04h edge=%0d", mon_e.addr, r_data, mon_e.data, cyc);
                check("read_data", 32'(r_data), 32'(mon_e.data));
                check("read_edge", 32'(cyc), 32'(mon_e.edge_n + RL - 1));
            end
        end
    end

    // Holds each requested valid until the DUT accepts it, updating the model at the accept edge.
    task automatic xfer(input bit do_rd, input logic [AW-1:0] ra,
                        input bit do_wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        bit rp = do_rd;
        bit wp = do_wr;
        int guard = 0;
        while ((rp || wp) && guard < 200) begin
            @(negedge clk);
            r_avalid = rp;
            r_addr   = ra;
            w_valid  = wp;
            w_addr   = wa;
            w_data   = wd;
            if (wp && w_ready) begin
                model_mem[idx_of(wa)] = wd;
                $display("WRITE addr=0x%04h data=0x%04h edge=%0d", wa, wd, cyc + 1);
                wp = 1'b0;
            end
            if (rp && r_aready) begin
                exp_q.push_back('{data: model_mem[idx_of(ra)], edge_n: cyc + 1, addr: ra});
                rp = 1'b0;
            end
            guard++;
        end
        check("xfer_accepted", {30'd0, rp, wp}, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            r_avalid = 1'b0;
            w_valid  = 1'b0;
        end
    endtask

    task automatic do_reset_and_init(input string tag);
        int ready_edge = -1;
        @(negedge clk);
        reset = 1'b1;
        r_avalid = 1'b0;
        w_valid  = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NW; i++) model_mem[i] = '0;
        repeat (3) @(negedge clk);
        check({tag, "_rst_r_aready"}, 32'(r_aready), 32'd0);
        check({tag, "_rst_w_ready"},  32'(w_ready),  32'd0);
        check({tag, "_rst_r_dvalid"}, 32'(r_dvalid), 32'd0);
        check({tag, "_rst_r_data"},   32'(r_data),   32'd0);
        reset = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (r_aready || w_ready) begin
                ready_edge = i;
                break;
            end
        end
        $display("INIT %s ready after edge %0d", tag, ready_edge);
        check({tag, "_init_edges"}, 32'(ready_edge), 32'(NW));
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        int            kind;

        for (int i = 0; i < NW; i++) model_mem[i] = '0;

        do_reset_and_init("first");

        // Freshly cleared memory.
        xfer(1'b1, 16'h0010, 1'b0, '0, '0);
        idle(1);

        // Write then read back.
        xfer(1'b0, '0, 1'b1, 16'h0005, 16'hBEEF);
        xfer(1'b1, 16'h0005, 1'b0, '0, '0);
        idle(1);

        // Same-edge write and read to one word.
        xfer(1'b1, 16'h0007, 1'b1, 16'h0007, 16'h1234);
        idle(RL + 2);
        check("model_write_first", 32'(model_mem[7]), 32'h1234);

        // Pre-fill 0..7, then stream reads back-to-back.
        for (int i = 0; i < 8; i++) xfer(1'b0, '0, 1'b1, AW'(i), DW'(16'h100 + i));
        for (int i = 0; i < 8; i++) xfer(1'b1, AW'(i), 1'b0, '0, '0);
        idle(RL + 2);

        // Address aliasing above MEM_DEPTH_LOG2.
        xfer(1'b0, '0, 1'b1, 16'h0103, 16'hA5A5);
        xfer(1'b1, 16'h0003, 1'b0, '0, '0);
        idle(RL + 2);

        // Randomized mix on a small aliased address set to force collisions.
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 3));
            ra = {6'($urandom_range(0, 3)), 2'b00, 8'($urandom_range(0, 15))};
            wa = {6'($urandom_range(0, 3)), 2'b00, 8'($urandom_range(0, 15))};
            wd = DW'($urandom);
            if (kind == 3) wa = ra;
            case (kind)
                0:       xfer(1'b1, ra, 1'b0, wa, wd);
                1:       xfer(1'b0, ra, 1'b1, wa, wd);
                default: xfer(1'b1, ra, 1'b1, wa, wd);
            endcase
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(RL + 3);
        check("drained_before_reset", 32'(exp_q.size()), 32'd0);

        // Reset while a read is in flight and another is still requested.
        xfer(1'b0, '0, 1'b1, 16'h0005, 16'hBEEF);
        xfer(1'b1, 16'h0005, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midop_rst_r_dvalid", 32'(r_dvalid), 32'd0);
        do_reset_and_init("midop");
        idle(RL + 2);
        xfer(1'b1, 16'h0005, 1'b0, '0, '0);
        idle(RL + 3);

        check("pending_reads", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

endmodule
